// File: rtl/fetch_aligner_if.sv
// Fetch-aligner bus: icache word request/response, redirect, and instruction output.
// The master drives redirects, icache words and instruction acceptance. The slave is the aligner.
interface fetch_aligner_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  flush_in;
  logic [ADDR_WIDTH-1:0] flush_pc_in;
  logic [ADDR_WIDTH-1:0] fetch_addr_out;
  logic                  word_valid_in;
  logic [31:0]           word_in;
  logic                  word_ready_out;
  logic                  inst_valid_out;
  logic [31:0]           inst_out;
  logic [ADDR_WIDTH-1:0] inst_pc_out;
  logic                  inst_is_c_out;
  logic                  inst_ready_in;

  modport master (
    output flush_in, flush_pc_in, word_valid_in, word_in, inst_ready_in,
    input  fetch_addr_out, word_ready_out, inst_valid_out, inst_out,
           inst_pc_out, inst_is_c_out
  );

  modport slave (
    input  flush_in, flush_pc_in, word_valid_in, word_in, inst_ready_in,
    output fetch_addr_out, word_ready_out, inst_valid_out, inst_out,
           inst_pc_out, inst_is_c_out
  );
endinterface

// File: rtl/fetch_aligner.sv
// IF-stage aligner: turns word-aligned icache words into 16/32-bit raw instructions with PCs.
// Define FETCH_ALIGNER_RVC_EN to enable compressed parcels; otherwise every instruction is 32-bit.
module fetch_aligner #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic           clk_in,
  input  logic           rst_in,
  fetch_aligner_if.slave bus
);

`ifdef FETCH_ALIGNER_RVC_EN
  localparam logic [ADDR_WIDTH-1:0] PC_MASK    = ~ADDR_WIDTH'(1);
  localparam logic                  RESET_DROP = RESET_PC[1];
`else
  localparam logic [ADDR_WIDTH-1:0] PC_MASK    = ~ADDR_WIDTH'(3);
  localparam logic                  RESET_DROP = 1'b0;
`endif
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

  logic [47:0]           buf_q, buf_d, buf_pop;
  logic [1:0]            cnt_q, cnt_d, cnt_pop;
  logic [ADDR_WIDTH-1:0] head_pc_q, head_pc_d;
  logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic                  drop_half_q, drop_half_d;
  logic                  head_is_c, inst_valid, word_ready, pop, push;
  logic [15:0]           par_lo, par_hi;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
`ifdef FETCH_ALIGNER_RVC_EN
    head_is_c = (buf_q[1:0] != 2'b11);
`else
    head_is_c = 1'b0;
`endif
    inst_valid = (cnt_q >= 2'd2) | ((cnt_q == 2'd1) & head_is_c);
    word_ready = (cnt_q <= 2'd1);
    pop        = inst_valid & bus.inst_ready_in;
    push       = bus.word_valid_in & word_ready & ~bus.flush_in;

    buf_pop   = buf_q;
    cnt_pop   = cnt_q;
    head_pc_d = head_pc_q;
    if (pop) begin
      if (head_is_c) begin
        buf_pop   = {16'h0, buf_q[47:16]};
        cnt_pop   = cnt_q - 2'd1;
        head_pc_d = head_pc_q + ADDR_WIDTH'(2);
      end else begin
        buf_pop   = {32'h0, buf_q[47:32]};
        cnt_pop   = cnt_q - 2'd2;
        head_pc_d = head_pc_q + ADDR_WIDTH'(4);
      end
    end

    // With drop_half set the first halfword of the word precedes the target PC.
    par_lo = drop_half_q ? bus.word_in[31:16] : bus.word_in[15:0];
    par_hi = bus.word_in[31:16];

    buf_d        = buf_pop;
    cnt_d        = cnt_pop;
    fetch_addr_d = fetch_addr_q;
    drop_half_d  = drop_half_q;
    if (push) begin
      fetch_addr_d = fetch_addr_q + ADDR_WIDTH'(4);
      drop_half_d  = 1'b0;
      cnt_d        = cnt_pop + (drop_half_q ? 2'd1 : 2'd2);
      case (cnt_pop)
        2'd0:    buf_d[31:0]  = {par_hi, par_lo};
        2'd1:    buf_d[47:16] = {par_hi, par_lo};
        default: buf_d        = buf_pop;
      endcase
    end

    if (bus.flush_in) begin
      buf_d        = buf_q;
      cnt_d        = 2'd0;
      head_pc_d    = bus.flush_pc_in & PC_MASK;
      fetch_addr_d = bus.flush_pc_in & WORD_MASK;
`ifdef FETCH_ALIGNER_RVC_EN
      drop_half_d  = bus.flush_pc_in[1];
`else
      drop_half_d  = 1'b0;
`endif
    end
  end

  // NOTE: state uses non-blocking assignments; the parcel buffer is reset too so
  // inst_out reads as zero straight out of reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      buf_q        <= '0;
      cnt_q        <= 2'd0;
      head_pc_q    <= RESET_PC & PC_MASK;
      fetch_addr_q <= RESET_PC & WORD_MASK;
      drop_half_q  <= RESET_DROP;
    end else begin
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      head_pc_q    <= head_pc_d;
      fetch_addr_q <= fetch_addr_d;
      drop_half_q  <= drop_half_d;
    end
  end

  always_comb begin
    bus.fetch_addr_out = fetch_addr_q;
    bus.word_ready_out = word_ready;
    bus.inst_valid_out = inst_valid;
    bus.inst_is_c_out  = head_is_c;
    bus.inst_out       = head_is_c ? {16'h0, buf_q[15:0]} : buf_q[31:0];
    bus.inst_pc_out    = head_pc_q;
  end

endmodule

// File: tb/tb_fetch_aligner.sv
// Directed table-driven bench for fetch_aligner; expectations track FETCH_ALIGNER_RVC_EN.
module tb_fetch_aligner;
  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  fetch_aligner_if #(.ADDR_WIDTH(32)) bus ();
  fetch_aligner #(.ADDR_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        wv;
    logic [31:0] word;
    logic        ir;
    logic        fl;
    logic [31:0] fpc;
    logic        ev;
    logic [31:0] eout;
    logic [31:0] epc;
    logic        ec;
    logic        erdy;
    logic [31:0] efa;
  } vec_t;

  vec_t vecs[$];

  // Expected outputs hold for the cycle; the inputs are applied for the edge that ends it.
  function automatic vec_t mk(logic wv, logic [31:0] word, logic ir, logic fl, logic [31:0] fpc,
                              logic ev, logic [31:0] eout, logic [31:0] epc, logic ec,
                              logic erdy, logic [31:0] efa);
    vec_t v;
    v.wv = wv; v.word = word; v.ir = ir; v.fl = fl; v.fpc = fpc;
    v.ev = ev; v.eout = eout; v.epc = epc; v.ec = ec; v.erdy = erdy; v.efa = efa;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [31:0] word, input logic ir,
                       input logic fl, input logic [31:0] fpc);
    bus.word_valid_in = wv;
    bus.word_in       = word;
    bus.inst_ready_in = ir;
    bus.flush_in      = fl;
    bus.flush_pc_in   = fpc;
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    check({tag, " valid"}, 32'(bus.inst_valid_out), 32'(v.ev));
    check({tag, " ready"}, 32'(bus.word_ready_out), 32'(v.erdy));
    check({tag, " fetch_addr"}, bus.fetch_addr_out, v.efa);
    if (v.ev) begin
      check({tag, " inst"}, bus.inst_out, v.eout);
      check({tag, " pc"}, bus.inst_pc_out, v.epc);
      check({tag, " is_c"}, 32'(bus.inst_is_c_out), 32'(v.ec));
    end
  endtask

  task automatic step(input int idx, input vec_t v);
    check_outs($sformatf("v%0d", idx), v);
    drive(v.wv, v.word, v.ir, v.fl, v.fpc);
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    //          wv  word          ir  fl  fpc      ev  eout          epc      ec  rdy fa
`ifdef FETCH_ALIGNER_RVC_EN
    vecs.push_back(mk(1, 32'h45014485, 1, 0, 32'h0,   0, 32'h0,        32'h0,   0, 1, 32'h0));
    vecs.push_back(mk(1, 32'h00934505, 1, 0, 32'h0,   1, 32'h00004485, 32'h0,   1, 0, 32'h4));
    vecs.push_back(mk(1, 32'h00934505, 1, 0, 32'h0,   1, 32'h00004501, 32'h2,   1, 1, 32'h4));
    vecs.push_back(mk(1, 32'h12340013, 1, 0, 32'h0,   1, 32'h00004505, 32'h4,   1, 0, 32'h8));
    vecs.push_back(mk(0, 32'h0,        1, 0, 32'h0,   0, 32'h0,        32'h0,   0, 1, 32'h8));
    vecs.push_back(mk(1, 32'h12340013, 1, 0, 32'h0,   0, 32'h0,        32'h0,   0, 1, 32'h8));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 32'hDEADBEEF, 0, 0, 32'h0, 1, 32'h00130093, 32'h6,   0, 0, 32'hC));
    vecs.push_back(mk(1, 32'hDEADBEEF, 1, 1, 32'h102, 1, 32'h00130093, 32'h6,   0, 0, 32'hC));
    vecs.push_back(mk(1, 32'h8082ABCD, 0, 0, 32'h0,   0, 32'h0,        32'h0,   0, 1, 32'h100));
    vecs.push_back(mk(0, 32'h0,        1, 0, 32'h0,   1, 32'h00008082, 32'h102, 1, 1, 32'h104));
    vecs.push_back(mk(0, 32'h0,        0, 0, 32'h0,   0, 32'h0,        32'h0,   0, 1, 32'h104));
`else
    vecs.push_back(mk(1, 32'h00130093, 1, 0, 32'h0,   0, 32'h0,        32'h0,   0, 1, 32'h0));
    vecs.push_back(mk(1, 32'h00200113, 1, 0, 32'h0,   1, 32'h00130093, 32'h0,   0, 0, 32'h4));
    vecs.push_back(mk(1, 32'h00200113, 1, 0, 32'h0,   0, 32'h0,        32'h0,   0, 1, 32'h4));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 32'hDEADBEEF, 0, 0, 32'h0, 1, 32'h00200113, 32'h4,   0, 0, 32'h8));
    vecs.push_back(mk(1, 32'h11111111, 1, 1, 32'h102, 1, 32'h00200113, 32'h4,   0, 0, 32'h8));
    vecs.push_back(mk(1, 32'h8082ABCD, 0, 0, 32'h0,   0, 32'h0,        32'h0,   0, 1, 32'h100));
    vecs.push_back(mk(0, 32'h0,        1, 0, 32'h0,   1, 32'h8082ABCD, 32'h100, 0, 0, 32'h104));
    vecs.push_back(mk(0, 32'h0,        0, 0, 32'h0,   0, 32'h0,        32'h0,   0, 1, 32'h104));
`endif

    drive(0, 32'h0, 0, 0, 32'h0);
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;

    check("reset valid", 32'(bus.inst_valid_out), 32'h0);
    check("reset inst", bus.inst_out, 32'h0);
    check("reset fetch_addr", bus.fetch_addr_out, 32'h0);
    check("reset ready", 32'(bus.word_ready_out), 32'h1);

    for (int i = 0; i < vecs.size(); i++) step(i, vecs[i]);

    // Reset and flush in the same cycle: reset must win over the redirect and the word.
    drive(1, 32'h12345678, 1, 1, 32'h200);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    check_outs("rstflush", mk(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 32'h0));
    drive(1, 32'h00004505, 0, 0, 32'h0);
    @(posedge clk_in);
    #1;
`ifdef FETCH_ALIGNER_RVC_EN
    check_outs("after_rst w", mk(0, 0, 0, 0, 0, 1, 32'h00004505, 32'h0, 1, 0, 32'h4));
    drive(0, 32'h0, 1, 0, 32'h0);
    @(posedge clk_in);
    #1;
    check_outs("after_rst p", mk(0, 0, 0, 0, 0, 1, 32'h00000000, 32'h2, 1, 1, 32'h4));
`else
    check_outs("after_rst w", mk(0, 0, 0, 0, 0, 1, 32'h00004505, 32'h0, 0, 0, 32'h4));
    drive(0, 32'h0, 1, 0, 32'h0);
    @(posedge clk_in);
    #1;
    check_outs("after_rst p", mk(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 32'h4));
`endif
    drive(0, 32'h0, 0, 0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
